// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage control: PC register, IF/ID pipeline register,
// redirect/flush/stall arbitration, stall statistics and a debug FSM.
`timescale 1ns/1ps

module fetch_stage_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IF_ID,
    input  logic        flush_IF_ID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [7:0]  stall_count,
    output logic        stall_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        ACT_FETCH,
        ACT_STALL,
        ACT_FLUSH,
        ACT_REDIRECT
    } fetch_action_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic [31:0]   pc_q;
    logic [31:0]   pc_plus4;
    logic [31:0]   redirect_target;
    logic [3:0]    stall_run_q;
    fetch_state_e  cur_state;
    fetch_action_e action;

    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // NOTE: every path assigns a default first, so this decode can never
    // infer a latch when a new condition is added later.
    always_comb begin
        action = ACT_FETCH;
        if (redirect_valid)
            action = ACT_REDIRECT;
        else if (flush_IF_ID)
            action = ACT_FLUSH;
        else if (stall_IF_ID)
            action = ACT_STALL;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0000_0000;
            if_id_valid <= 1'b0;
        end else begin
            case (action)
                ACT_REDIRECT: begin
                    pc_q        <= redirect_target;
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                end
                ACT_FLUSH: begin
                    pc_q        <= pc_plus4;
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                end
                ACT_STALL: begin
                    pc_q        <= pc_q;
                end
                default: begin
                    pc_q        <= pc_plus4;
                    if_id_instr <= instr_in;
                    if_id_pc4   <= pc_plus4;
                    if_id_valid <= 1'b1;
                end
            endcase
        end
    end

    // The run counter saturates at 15, so seeing 15 on a stall edge means
    // this edge applies the 16th consecutive stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count   <= 8'd0;
            stall_run_q   <= 4'd0;
            stall_timeout <= 1'b0;
        end else if (action == ACT_STALL) begin
            if (stall_count != 8'hFF)
                stall_count <= stall_count + 8'd1;
            if (stall_run_q != 4'hF)
                stall_run_q <= stall_run_q + 4'd1;
            else
                stall_timeout <= 1'b1;
        end else begin
            stall_run_q <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_RUN;
        end else begin
            case (cur_state)
                ST_RUN: begin
                    if (action == ACT_REDIRECT)
                        cur_state <= ST_REDIR;
                    else if (action == ACT_STALL)
                        cur_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (action == ACT_REDIRECT)
                        cur_state <= ST_REDIR;
                    else if (action != ACT_STALL)
                        cur_state <= ST_RUN;
                end
                ST_REDIR: begin
                    if (action == ACT_REDIRECT)
                        cur_state <= ST_REDIR;
                    else if (action == ACT_STALL)
                        cur_state <= ST_HOLD;
                    else
                        cur_state <= ST_RUN;
                end
                default: cur_state <= ST_RUN;
            endcase
        end
    end

    assign pc_out = pc_q;
    assign state  = cur_state;

endmodule
